// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch and data access.
// Data requests win by default; a saturating counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req_valid,
  input  logic [31:0] imem_req_addr,
  output logic        imem_req_ready,
  output logic        imem_resp_valid,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_valid,
  input  logic [31:0] dmem_req_addr,
  input  logic        dmem_req_fcn,
  input  logic [2:0]  dmem_req_typ,
  input  logic [31:0] dmem_req_data,
  output logic        dmem_req_ready,
  output logic        dmem_resp_valid,
  output logic [31:0] dmem_resp_data,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_fcn,
  output logic [2:0]  mem_req_typ,
  output logic [31:0] mem_req_data,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        cmiss_stall
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;

  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       sel_imem;
  logic       accept;

  // Selection is only meaningful in IDLE; outside IDLE the request valid is forced low.
  always_comb begin
    sel_imem      = imem_req_valid & (~dmem_req_valid | (starve_cnt == LIMIT));
    mem_req_valid = (state == IDLE) & (imem_req_valid | dmem_req_valid);
    accept        = mem_req_valid & mem_req_ready;

    if (sel_imem) begin
      mem_req_addr = imem_req_addr;
      mem_req_fcn  = 1'b0;
      mem_req_typ  = MT_W;
      mem_req_data = 32'd0;
    end else begin
      mem_req_addr = dmem_req_addr;
      mem_req_fcn  = dmem_req_fcn;
      mem_req_typ  = dmem_req_typ;
      mem_req_data = dmem_req_data;
    end

    imem_req_ready = accept & sel_imem;
    dmem_req_ready = accept & ~sel_imem;
  end

  // Responses are routed straight through to whichever side owns the transaction.
  always_comb begin
    imem_resp_valid = (state == WAIT_I) & mem_resp_valid;
    dmem_resp_valid = (state == WAIT_D) & mem_resp_valid;
    imem_resp_data  = imem_resp_valid ? mem_resp_data : 32'd0;
    dmem_resp_data  = dmem_resp_valid ? mem_resp_data : 32'd0;
    cmiss_stall     = (imem_req_valid & ~imem_resp_valid) |
                      (dmem_req_valid & ~dmem_resp_valid);
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_imem) begin
            state_nxt  = WAIT_I;
            starve_nxt = 4'd0;
          end else begin
            state_nxt = WAIT_D;
            if (imem_req_valid && (starve_cnt < LIMIT)) begin
              starve_nxt = starve_cnt + 4'd1;
            end
          end
        end
      end
      WAIT_I, WAIT_D: begin
        if (mem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level model of who owns the shared memory.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_fcn;
  logic [2:0]  dmem_req_typ;
  logic [31:0] dmem_req_data;
  logic        dmem_req_ready;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_fcn;
  logic [2:0]  mem_req_typ;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        cmiss_stall;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: owner 0 = memory free, 1 = fetch outstanding, 2 = data outstanding.
  // dmem_streak = data grants handed out since the waiting fetch was last served.
  int owner = 0;
  int dmem_streak = 0;
  bit exp_acc;
  bit exp_sel_i;

  logic        s_iready, s_dready, s_iresp, s_dresp, s_cmiss, s_mvalid, s_mfcn;
  logic [31:0] s_idata, s_ddata, s_mdata;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
    .dmem_req_fcn(dmem_req_fcn), .dmem_req_typ(dmem_req_typ),
    .dmem_req_data(dmem_req_data), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cmiss_stall(cmiss_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predicts every output from the model and the current inputs, then snapshots the DUT.
  task automatic checkOutput();
    logic exp_mv, exp_ire, exp_dre, exp_cm;
    if (!rst_n) begin
      owner = 0;
      dmem_streak = 0;
    end
    exp_mv    = (owner == 0) && (imem_req_valid || dmem_req_valid);
    exp_sel_i = imem_req_valid && (!dmem_req_valid || dmem_streak == STARVE_LIMIT);
    exp_acc   = exp_mv && mem_req_ready;
    exp_ire   = (owner == 1) && mem_resp_valid;
    exp_dre   = (owner == 2) && mem_resp_valid;
    exp_cm    = (imem_req_valid && !exp_ire) || (dmem_req_valid && !exp_dre);

    checkValue("mem_req_valid", 32'(mem_req_valid), 32'(exp_mv));
    if (exp_mv) begin
      checkValue("mem_req_addr", mem_req_addr, exp_sel_i ? imem_req_addr : dmem_req_addr);
      checkValue("mem_req_fcn", 32'(mem_req_fcn), exp_sel_i ? 32'd0 : 32'(dmem_req_fcn));
      checkValue("mem_req_typ", 32'(mem_req_typ), exp_sel_i ? 32'd3 : 32'(dmem_req_typ));
      checkValue("mem_req_data", mem_req_data, exp_sel_i ? 32'd0 : dmem_req_data);
    end
    checkValue("imem_req_ready", 32'(imem_req_ready), 32'(exp_acc && exp_sel_i));
    checkValue("dmem_req_ready", 32'(dmem_req_ready), 32'(exp_acc && !exp_sel_i));
    checkValue("imem_resp_valid", 32'(imem_resp_valid), 32'(exp_ire));
    checkValue("dmem_resp_valid", 32'(dmem_resp_valid), 32'(exp_dre));
    if (exp_ire) checkValue("imem_resp_data", imem_resp_data, mem_resp_data);
    if (exp_dre) checkValue("dmem_resp_data", dmem_resp_data, mem_resp_data);
    if (!rst_n) begin
      checkValue("rst_imem_resp_data", imem_resp_data, 32'd0);
      checkValue("rst_dmem_resp_data", dmem_resp_data, 32'd0);
    end
    checkValue("cmiss_stall", 32'(cmiss_stall), 32'(exp_cm));

    s_iready = imem_req_ready;  s_dready = dmem_req_ready;
    s_iresp  = imem_resp_valid; s_dresp  = dmem_resp_valid;
    s_idata  = imem_resp_data;  s_ddata  = dmem_resp_data;
    s_cmiss  = cmiss_stall;     s_mvalid = mem_req_valid;
    s_mdata  = mem_req_data;    s_mfcn   = mem_req_fcn;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    if (rst_n) begin
      if (owner == 0) begin
        if (exp_acc) begin
          owner = exp_sel_i ? 1 : 2;
          if (exp_sel_i) dmem_streak = 0;
          else if (imem_req_valid && dmem_streak < STARVE_LIMIT) dmem_streak++;
        end
      end else if (mem_resp_valid) begin
        owner = 0;
      end
    end
    @(negedge clk);
  endtask

  // Fetch held valid while data issues n_loads reads back-to-back; memory answers one cycle after each accept.
  task automatic runStarvation(input int n_loads);
    int grants[$];
    int expg[$];
    int left;
    int pre;
    bit pending;
    left = n_loads;
    pending = 1'b0;
    imem_req_valid = 1'b1; imem_req_addr = 32'h300;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h9000;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd3; dmem_req_data = 32'd0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 2 * (n_loads + 1); c++) begin
      mem_resp_valid = pending;
      mem_resp_data  = $urandom;
      applyStimulus();
      pending = s_iready | s_dready;
      if (s_iready) grants.push_back(1);
      if (s_dready) grants.push_back(2);
      if (s_iresp) imem_req_valid = 1'b0;
      if (s_dresp) begin
        left--;
        if (left == 0) dmem_req_valid = 1'b0;
        else dmem_req_addr = dmem_req_addr + 32'd4;
      end
    end
    mem_resp_valid = 1'b0;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    pre = (n_loads < STARVE_LIMIT) ? n_loads : STARVE_LIMIT;
    for (int k = 0; k <= n_loads; k++) expg.push_back((k == pre) ? 1 : 2);
    checkValue("starve_grant_count", 32'(grants.size()), 32'(expg.size()));
    for (int k = 0; k < expg.size(); k++) begin
      checkValue("starve_grant_order", (k < grants.size()) ? 32'(grants[k]) : 32'd0, 32'(expg[k]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_valid = 1'b0; imem_req_addr = 32'd0;
    dmem_req_valid = 1'b0; dmem_req_addr = 32'd0;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd0; dmem_req_data = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;

    // Reset: outputs idle, then a valid fetch shows through while still in reset.
    @(negedge clk);
    applyStimulus();
    checkValue("reset_mem_req_valid", 32'(s_mvalid), 32'd0);
    imem_req_valid = 1'b1; imem_req_addr = 32'h100;
    applyStimulus();
    checkValue("reset_valid_passthrough", 32'(s_mvalid), 32'd1);
    checkValue("reset_no_ready", 32'(s_iready), 32'd0);
    rst_n = 1'b1;

    // Single fetch answered two cycles after accept.
    $display("[TB] single fetch");
    mem_req_ready = 1'b1;
    applyStimulus();
    checkValue("fetch_ready_pulse", 32'(s_iready), 32'd1);
    checkValue("fetch_stall_c0", 32'(s_cmiss), 32'd1);
    applyStimulus();
    checkValue("fetch_ready_once", 32'(s_iready), 32'd0);
    checkValue("fetch_stall_c1", 32'(s_cmiss), 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    applyStimulus();
    checkValue("fetch_resp_valid", 32'(s_iresp), 32'd1);
    checkValue("fetch_resp_data", s_idata, 32'h13);
    checkValue("fetch_stall_resp", 32'(s_cmiss), 32'd0);
    imem_req_valid = 1'b0; mem_resp_valid = 1'b0;
    applyStimulus();

    // Simultaneous fetch and load: load first, fetch right after the load response.
    $display("[TB] simultaneous requests");
    imem_req_valid = 1'b1; imem_req_addr = 32'h200;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h8000;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd3; dmem_req_data = 32'h1234_5678;
    applyStimulus();
    checkValue("simul_dmem_first", 32'(s_dready), 32'd1);
    checkValue("simul_imem_waits", 32'(s_iready), 32'd0);
    applyStimulus();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_0001;
    applyStimulus();
    checkValue("simul_dmem_resp", 32'(s_dresp), 32'd1);
    checkValue("simul_no_accept_in_resp", 32'(s_iready), 32'd0);
    dmem_req_valid = 1'b0; mem_resp_valid = 1'b0;
    applyStimulus();
    checkValue("simul_imem_next", 32'(s_iready), 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0093;
    applyStimulus();
    checkValue("simul_imem_resp", 32'(s_iresp), 32'd1);
    imem_req_valid = 1'b0; mem_resp_valid = 1'b0;

    $display("[TB] starvation");
    runStarvation(6);

    // Store word.
    $display("[TB] store");
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h40;
    dmem_req_fcn = 1'b1; dmem_req_typ = 3'd3; dmem_req_data = 32'hDEAD_BEEF;
    applyStimulus();
    checkValue("store_data", s_mdata, 32'hDEAD_BEEF);
    checkValue("store_fcn", 32'(s_mfcn), 32'd1);
    mem_resp_valid = 1'b1;
    applyStimulus();
    checkValue("store_ack", 32'(s_dresp), 32'd1);
    dmem_req_valid = 1'b0; mem_resp_valid = 1'b0;
    applyStimulus();

    // Memory not ready for three cycles, then accept and reset in WAIT_D.
    $display("[TB] stall and reset mid-transaction");
    imem_req_valid = 1'b1; imem_req_addr = 32'h500;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h44; dmem_req_fcn = 1'b0;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkValue("stall_valid_held", 32'(s_mvalid), 32'd1);
      checkValue("stall_no_ready", 32'(s_dready | s_iready), 32'd0);
      checkValue("stall_cmiss", 32'(s_cmiss), 32'd1);
    end
    mem_req_ready = 1'b1;
    applyStimulus();
    checkValue("stall_then_accept", 32'(s_dready), 32'd1);
    rst_n = 1'b0; mem_req_ready = 1'b0;
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    applyStimulus();
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    applyStimulus();
    checkValue("late_resp_no_dstrobe", 32'(s_dresp), 32'd0);
    checkValue("late_resp_no_istrobe", 32'(s_iresp), 32'd0);
    mem_resp_valid = 1'b0;
    runStarvation(5);

    // Randomized traffic with the bench acting as the shared memory.
    $display("[TB] random traffic");
    s_iresp = 1'b0; s_dresp = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (s_iresp) imem_req_valid = 1'b0;
      if (s_dresp) dmem_req_valid = 1'b0;
      if (!imem_req_valid && $urandom_range(0, 2) == 0) begin
        imem_req_valid = 1'b1;
        imem_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!dmem_req_valid && $urandom_range(0, 1) == 0) begin
        dmem_req_valid = 1'b1;
        dmem_req_addr  = $urandom;
        dmem_req_fcn   = 1'($urandom_range(0, 1));
        dmem_req_typ   = 3'($urandom_range(0, 7));
        dmem_req_data  = $urandom;
      end
      rst_n = ($urandom_range(0, 59) != 0);
      mem_req_ready  = rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_resp_valid = (owner != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_resp_data  = $urandom;
      applyStimulus();
    end
    rst_n = 1'b1;

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
